head_table_lookup: RTL

HEAD_TABLE_LOOKUP -- requirements
Module: head_table_lookup

---
 rtl/hash_table_pkg.sv | 47 ++++
 rtl/head_table_if.sv | 14 +
 rtl/ht_sync_fifo.sv | 42 ++++
 rtl/head_table_lookup.sv | 99 +++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared hash-table types and the bucket hash used by every lookup stage.
package hash_table;

    localparam int KEY_WIDTH      = 16;
    localparam int VALUE_WIDTH    = 16;
    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 8;
    localparam int KEY_CHUNKS     = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_DELETE = 2'd1,
        OP_SEARCH = 2'd2,
        OP_NOP    = 2'd3
    } ht_opcode_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_opcode_t             opcode;
    } ht_command_t;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_entry_t;

    typedef struct packed {
        ht_command_t               cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    // XOR-fold of the key into bucket-sized chunks; the top chunk is zero-padded.
    function automatic logic [BUCKET_WIDTH-1:0] calc_bucket(input logic [KEY_WIDTH-1:0] key);
        logic [KEY_CHUNKS*BUCKET_WIDTH-1:0] padded;
        logic [BUCKET_WIDTH-1:0]            h;
        padded                  = '0;
        padded[KEY_WIDTH-1:0]   = key;
        h                       = '0;
        for (int i = 0; i < KEY_CHUNKS; i++)
            h ^= padded[i*BUCKET_WIDTH +: BUCKET_WIDTH];
        return h;
    endfunction

endpackage

// File: rtl/head_table_if.sv
// Head-table RAM port: synchronous read with fixed latency plus a write port.
interface head_table_if;
    import hash_table::*;

    logic [BUCKET_WIDTH-1:0] rd_addr;
    logic                    rd_en;
    head_entry_t             rd_data;
    logic                    wr_en;
    logic [BUCKET_WIDTH-1:0] wr_addr;
    head_entry_t             wr_data;

    modport master (output rd_addr, rd_en, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, rd_en, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/ht_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is visible while not empty.
module ht_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   used
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign used    = wr_ptr - rd_ptr;

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_i) !(wr_en && full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i) !(rd_en && empty));
endmodule

// File: rtl/head_table_lookup.sv
// Hashes each command to a bucket, reads its head pointer and queues the result
// for the data-table search; credit flow control guarantees FIFO room.
module head_table_lookup
    import hash_table::*;
#(
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  ht_command_t      cmd_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    head_table_if.master     head_table_if,
    output ht_pdata_t        task_o,
    output logic             task_valid_o,
    input  logic             task_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        ht_command_t             cmd;
        logic [BUCKET_WIDTH-1:0] bucket;
    } stage_t;

    logic                          accept, pop;
    logic [BUCKET_WIDTH-1:0]       bucket, rd_addr_d, addr_q;
    logic [CW-1:0]                 credit;
    logic [RAM_LATENCY:1]          vld_pipe;
    stage_t [RAM_LATENCY:1]        dat_pipe;
    ht_pdata_t                     fifo_wdata;
    logic                          fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_used;

    // Credit counts FIFO entries plus reads in flight, so ready never looks at task_ready_i.
    assign cmd_ready_o = rst_i & (credit < CW'(FIFO_DEPTH));
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign bucket      = calc_bucket(cmd_i.key);
    assign rd_addr_d   = accept ? bucket : addr_q;

    assign head_table_if.rd_en   = accept;
    assign head_table_if.rd_addr = rd_addr_d;
    assign head_table_if.wr_en   = 1'b0;
    assign head_table_if.wr_addr = '0;
    assign head_table_if.wr_data = '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q   <= '0;
            vld_pipe <= '0;
            credit   <= '0;
        end else begin
            addr_q      <= rd_addr_d;
            vld_pipe[1] <= accept;
            for (int i = 2; i <= RAM_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            case ({accept, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        dat_pipe[1] <= '{cmd: cmd_i, bucket: bucket};
        for (int i = 2; i <= RAM_LATENCY; i++)
            dat_pipe[i] <= dat_pipe[i-1];
    end

    // Pipeline tail lines up with the cycle the RAM presents rd_data.
    assign fifo_wdata = '{cmd:          dat_pipe[RAM_LATENCY].cmd,
                          bucket:       dat_pipe[RAM_LATENCY].bucket,
                          head_ptr:     head_table_if.rd_data.ptr,
                          head_ptr_val: head_table_if.rd_data.ptr_val};

    assign task_valid_o = ~fifo_empty;
    assign pop          = task_valid_o & task_ready_i;

    ht_sync_fifo #(
        .WIDTH ($bits(ht_pdata_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (vld_pipe[RAM_LATENCY]),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (task_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .used    (fifo_used)
    );

    a_credit_covers_fifo: assert property (@(posedge clk_i) disable iff (!rst_i)
                                           {1'b0, credit} >= {1'b0, fifo_used});
    a_credit_room:        assert property (@(posedge clk_i) disable iff (!rst_i)
                                           !(vld_pipe[RAM_LATENCY] && fifo_full && !pop));
endmodule
